// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: turns ALU operation requests into RV32I R-type / I-type
// instruction words, buffers them in a small FIFO and streams them with a
// word address to the instruction-memory loader.
// Optional build macro ALU_ENC_NOP_PAD_EN: a 'finish' pulse stops user input
// and pads the rest of the program with NOPs (addi x0,x0,0).
//
// Handshake rule on both sides: a transfer happens at a rising clk edge where
// valid and ready are both high; ready never depends on the same side's
// valid, and a producer holds its payload stable until the transfer.
module alu_instr_encoder #(
  parameter int DEPTH      = 4,
  parameter int PROG_WORDS = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_ctrl,
  input  logic              is_imm,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [11:0]       imm,
  input  logic              finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              illegal,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(PROG_WORDS + 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
`ifdef ALU_ENC_NOP_PAD_EN
  localparam logic [1:0] S_PAD  = 2'd2;
`endif

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [1:0]       r_state;
  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_count;
  logic [CNT_W-1:0] r_push_cnt;
  logic [CNT_W-1:0] r_pop_cnt;
  logic             r_illegal;

  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_bad_req;
  logic [31:0] w_enc_word;
  logic [31:0] w_push_data;
  logic        w_full;
  logic        w_budget;
  logic        w_accept;
  logic        w_user_push;
  logic        w_pad_push;
  logic        w_push;
  logic        w_pop;

  // Decode the ALU code into funct3/funct7 and flag codes with no encoding.
  always_comb begin
    w_funct3  = 3'b000;
    w_funct7  = 7'b0000000;
    w_bad_req = 1'b0;
    case (alu_ctrl)
      3'b000: w_funct3 = 3'b000;
      3'b001: begin
        w_funct7  = 7'b0100000;
        w_bad_req = is_imm;
      end
      3'b101: w_funct3 = 3'b010;
      3'b011: w_funct3 = 3'b110;
      3'b010: w_funct3 = 3'b111;
      default: w_bad_req = 1'b1;
    endcase
  end

  assign w_enc_word = is_imm ? {imm, rs1, w_funct3, rd, 7'b0010011}
                             : {w_funct7, rs2, rs1, w_funct3, rd, 7'b0110011};

  assign w_full      = (r_count == OCC_W'(DEPTH));
  assign w_budget    = (r_push_cnt < CNT_W'(PROG_WORDS));
  assign in_ready    = (r_state == S_RUN) & ~w_full & w_budget;
  assign w_accept    = in_valid & in_ready;
  assign w_user_push = w_accept & ~w_bad_req;

`ifdef ALU_ENC_NOP_PAD_EN
  assign w_pad_push  = (r_state == S_PAD) & ~w_full & w_budget;
`else
  logic w_unused_finish;
  assign w_unused_finish = finish;
  assign w_pad_push  = 1'b0;
`endif

  // User push and pad push live in different states, so they never collide.
  assign w_push      = w_user_push | w_pad_push;
  assign w_push_data = w_pad_push ? NOP_WORD : w_enc_word;

  assign out_valid = (r_count != '0) & (r_state != S_DONE);
  assign w_pop     = out_valid & out_ready;
  assign out_instr = out_valid ? r_mem[r_rptr] : 32'h0;
  assign out_addr  = ADDR_W'(r_pop_cnt);
  assign illegal   = r_illegal;
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  // FIFO storage: payload only, no reset needed since r_count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  // FIFO pointers, occupancy, program counters and the sticky illegal flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr     <= r_wptr + 1'b1;
        r_push_cnt <= r_push_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        r_pop_cnt <= r_pop_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept & w_bad_req) r_illegal <= 1'b1;
    end
  end

  // Program FSM: finishes once the last program word has been popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RUN;
    end else if (w_pop && (r_pop_cnt == CNT_W'(PROG_WORDS - 1))) begin
      r_state <= S_DONE;
    end
`ifdef ALU_ENC_NOP_PAD_EN
    else if ((r_state == S_RUN) && finish) begin
      r_state <= S_PAD;
    end
`endif
  end

endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Inverse of the ALU-control decode path: turns an ALU operation code plus register/immediate fields into 32-bit RV32I R-type or I-type instruction words.
- Words are buffered in a small FIFO and streamed with a word address to the instruction-memory loader.
- Test/boot infrastructure: builds ALU programs for the single-cycle core without an external assembler.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
PROG_WORDS, 64, program length in words; emission stops after this many
ADDR_W, 6, width of out_addr (≥ clog2(PROG_WORDS))

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request
alu_ctrl  in  3  ALU code: 000 add, 001 sub, 101 slt, 011 or, 010 and
is_imm  in  1  1 = I-type (OP-IMM), 0 = R-type (OP)
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2 (ignored when is_imm=1)
imm  in  12  immediate (ignored when is_imm=0)
finish  in  1  end-of-program pulse (used only with optional feature)
out_valid  out  1  out_instr/out_addr valid
out_ready  in  1  loader accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  word address of out_instr
illegal  out  1  sticky: an unencodable request was dropped
done  out  1  all PROG_WORDS words emitted

Behaviour:
- Reset is asynchronous and active-low on reset_n, single clock clk.
- Reset values:
  - state=RUN, FIFO empty.
  - out_valid=0, out_instr=0, out_addr=0.
  - illegal=0, done=0.
  - push and pop counters = 0.
- Reset mid-operation discards FIFO contents and counters.
- Encoding, funct3 by code: add 000, sub 000, slt 010, or 110, and 111.
  - R-type: {funct7, rs2, rs1, funct3, rd, 7'b0110011}; funct7 = 0100000 for sub, else 0000000.
  - I-type: {imm, rs1, funct3, rd, 7'b0010011}.
- Illegal requests:
  - alu_ctrl ∈ {100, 110, 111}, or sub with is_imm=1 (no subi).
  - Handshake still completes; no word is pushed and the push counter is unchanged.
  - illegal is set the following cycle and holds until reset.
- Accept: in_valid & in_ready at an edge.
  - in_ready = (state==RUN) & FIFO not full & push_cnt < PROG_WORDS.
  - in_ready is combinational from registered state only, never from in_valid.
- Latency: a word accepted at edge N appears on out_instr with out_valid=1 after edge N, provided the FIFO was empty. No combinational input→output path.
- Output handshake:
  - Pop on out_valid & out_ready.
  - out_instr/out_addr stay stable while out_valid & !out_ready.
  - out_addr = pop_cnt[ADDR_W-1:0], incremented on each pop. No wrap; counting stops at PROG_WORDS.
- Push and pop in the same cycle: occupancy unchanged. A full FIFO blocks input (no pass-through).
- States:
  - RUN → DONE when pop_cnt reaches PROG_WORDS (last word popped).
  - DONE: in_ready=0, out_valid=0, done=1 the cycle after the final pop. Exit only via reset.
  - PAD exists only with the optional feature.
- Input fields are sampled only on accept; changes while in_ready=0 are ignored.

Optional Feature:
ALU_ENC_NOP_PAD_EN
- Defined:
  - finish=1 in RUN moves to PAD the next cycle, and in_ready drops to 0.
  - In PAD, the internal generator pushes NOP 0x00000013 (addi x0,x0,0) whenever the FIFO is not full and push_cnt < PROG_WORDS.
  - Queued user words drain first, in order.
  - PAD → DONE when pop_cnt reaches PROG_WORDS.
  - finish together with in_valid in the same cycle: that request is still accepted.
  - finish in PAD or DONE: ignored.
- Undefined: the finish port exists but is ignored; no PAD state.

Test Plan:
- R-type encodes: add x3,x1,x2 → out_instr=0x002081B3, out_addr=0; then sub x5,x6,x7 → 0x407302B3, out_addr=1.
- I-type and logic: addi x1,x0,imm=0xFFF → 0xFFF00093; and x4,x4,x4 → 0x00427233; slti x2,x1,5 → 0x0050A113.
- Illegal: alu_ctrl=100, then sub with is_imm=1 → no out_valid for either, illegal=1 sticky; next legal add still gets out_addr=0.
- Backpressure: out_ready=0, push 5 requests with DEPTH=4 → in_ready=0 after 4 accepts, out_instr held constant; release → 4 words in order, addresses 0–3.
- Completion with PROG_WORDS=4: 4 words popped → done=1, in_ready=0, out_valid=0; reset_n low mid-stream → all outputs back to reset values immediately.
- ALU_ENC_NOP_PAD_EN, PROG_WORDS=4: one add, then finish → words 0x002081B3, 0x00000013 ×3 at addresses 0–3, then done=1.
